// File: rtl/x_ramd16_fifo_pkg.sv
// Shared constants, flag bundle and flag derivation for the 16-deep distributed-RAM FIFO.
`timescale 1ps/1ps
package x_ramd16_fifo_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    function automatic fifo_flags_t calc_flags(input logic [CW-1:0] count,
                                               input int af_level,
                                               input int ae_level);
        fifo_flags_t f;
        f.full         = (count == CW'(DEPTH));
        f.empty        = (count == '0);
        f.almost_full  = (int'(count) >= af_level);
        f.almost_empty = (int'(count) <= ae_level);
        return f;
    endfunction

endpackage

// File: rtl/x_ramd16_fifo_if.sv
// Write/read handshake and status bundle of the FIFO; master drives requests, slave is the FIFO.
`timescale 1ps/1ps
interface x_ramd16_fifo_if #(parameter int WIDTH = 8);
    import x_ramd16_fifo_pkg::*;

    logic             WR_EN;
    logic [WIDTH-1:0] DIN;
    logic             RD_EN;
    logic [WIDTH-1:0] DOUT;
    logic             FULL;
    logic             EMPTY;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;
    logic [CW-1:0]    COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output WR_EN, DIN, RD_EN,
        input  DOUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WR_EN, DIN, RD_EN,
        output DOUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/x_ramd16.sv
// 16x1 dual-port distributed RAM cell: synchronous write, asynchronous read, no reset.
`timescale 1ps/1ps
module X_RAMD16 #(
    parameter logic [15:0] INIT = 16'h0000
) (
    output logic O,
    input  logic CLK,
    input  logic I,
    input  logic WE,
    input  logic RADR0,
    input  logic RADR1,
    input  logic RADR2,
    input  logic RADR3,
    input  logic WADR0,
    input  logic WADR1,
    input  logic WADR2,
    input  logic WADR3
);

    logic [15:0] mem_q;
    logic [15:0] mem_d;
    logic [3:0]  wadr;
    logic [3:0]  radr;

    // Cells hold data relative to INIT, so the parameter defines the power-up image.
    always_comb begin
        wadr  = {WADR3, WADR2, WADR1, WADR0};
        radr  = {RADR3, RADR2, RADR1, RADR0};
        mem_d = mem_q;
        if (WE) begin
            mem_d[wadr] = I ^ INIT[wadr];
        end
        O = mem_q[radr] ^ INIT[radr];
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/x_ramd16_fifo_ctrl.sv
// Pointer, occupancy, flag and reject-pulse control for the FIFO; drives the RAM address/WE pins.
`timescale 1ps/1ps
module x_ramd16_fifo_ctrl
    import x_ramd16_fifo_pkg::*;
#(
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          we,
    output logic          rd_ok,
    output logic [AW-1:0] wadr,
    output logic [AW-1:0] radr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    fifo_flags_t   flags_q, flags_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_ok;

    // Full/empty are told apart by count, so pointers simply wrap 15 -> 0.
    always_comb begin
        wr_ok       = wr_en & ~flags_q.full;
        rd_ok       = rd_en & ~flags_q.empty;
        wptr_d      = wr_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = rd_ok ? rptr_q + 1'b1 : rptr_q;
        count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
        flags_d     = calc_flags(count_d, AF_LEVEL, AE_LEVEL);
        overflow_d  = wr_en & flags_q.full;
        underflow_d = rd_en & flags_q.empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            flags_q     <= FLAGS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign we           = wr_ok;
    assign wadr         = wptr_q;
    assign radr         = rptr_q;
    assign count        = count_q;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: rtl/x_ramd16_fifo.sv
// 16-deep FIFO top: one X_RAMD16 cell per data bit plus the registered read port.
`timescale 1ps/1ps
module x_ramd16_fifo
    import x_ramd16_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic           CLK,
    input  logic           RSTN,
    x_ramd16_fifo_if.slave bus
);

    logic             we;
    logic             rd_ok;
    logic [AW-1:0]    wadr;
    logic [AW-1:0]    radr;
    logic [WIDTH-1:0] ram_o;
    logic [WIDTH-1:0] dout_q, dout_d;

    x_ramd16_fifo_ctrl #(
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_ctrl (
        .clk          (CLK),
        .rst_n        (RSTN),
        .wr_en        (bus.WR_EN),
        .rd_en        (bus.RD_EN),
        .we           (we),
        .rd_ok        (rd_ok),
        .wadr         (wadr),
        .radr         (radr),
        .count        (bus.COUNT),
        .full         (bus.FULL),
        .empty        (bus.EMPTY),
        .almost_full  (bus.ALMOST_FULL),
        .almost_empty (bus.ALMOST_EMPTY),
        .overflow     (bus.OVERFLOW),
        .underflow    (bus.UNDERFLOW)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_ram
        X_RAMD16 #(
            .INIT (16'h0000)
        ) u_ram (
            .O     (ram_o[i]),
            .CLK   (CLK),
            .I     (bus.DIN[i]),
            .WE    (we),
            .RADR0 (radr[0]),
            .RADR1 (radr[1]),
            .RADR2 (radr[2]),
            .RADR3 (radr[3]),
            .WADR0 (wadr[0]),
            .WADR1 (wadr[1]),
            .WADR2 (wadr[2]),
            .WADR3 (wadr[3])
        );
    end

    // Standard (non fall-through) read: the async RAM word is captured only on an accepted read.
    always_comb begin
        dout_d = rd_ok ? ram_o : dout_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.DOUT = dout_q;

endmodule

// File: doc/x_ramd16_fifo.md
# x_ramd16_fifo

Synchronous 16-deep, WIDTH-bit FIFO built on distributed dual-port RAM: one X_RAMD16 16x1 primitive per data bit, with synchronous write and asynchronous read. This block holds the write and read pointers, the occupancy count, the status flags and a registered read port. It sits directly in front of the RAM cells and drives their WADR, RADR and WE pins. It is the standard small elastic buffer used in unisim-level simulation models.

## Interface
Parameters:
- WIDTH, 8: data width; equals the number of RAM cells.
- AF_LEVEL, 14: ALMOST_FULL asserts when count >= AF_LEVEL (legal range 1..15).
- AE_LEVEL, 2: ALMOST_EMPTY asserts when count <= AE_LEVEL (legal range 1..15).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RSTN  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- WR_EN  in  1  write request.
- DIN  in  WIDTH  write data.
- RD_EN  in  1  read request.
- DOUT  out  WIDTH  read data, registered.
- FULL  out  1  count == 16.
- EMPTY  out  1  count == 0.
- ALMOST_FULL  out  1  count >= AF_LEVEL.
- ALMOST_EMPTY  out  1  count <= AE_LEVEL.
- COUNT  out  5  occupancy, 0..16.
- OVERFLOW  out  1  one-cycle pulse: a write was rejected.
- UNDERFLOW  out  1  one-cycle pulse: a read was rejected.

## Operation
- Definitions: wr_ok = WR_EN & ~FULL; rd_ok = RD_EN & ~EMPTY. Both use the current registered flags.
- Write: on wr_ok, RAM WE=1 with WADR=wptr. Data lands in mem[wptr] at the edge. wptr increments mod 16.
- Read: RADR=rptr at all times. On rd_ok, DOUT <= mem[rptr] (async RAM output sampled at the edge). rptr increments mod 16.
- When rd_ok is 0, DOUT holds its value. Mode is standard read, not first-word-fall-through.
- Count update: count_next = count + wr_ok - rd_ok. A simultaneous wr_ok and rd_ok leaves count unchanged.
- Flags are registered and computed from count_next, so they are valid in the same cycle as COUNT.
- Full: the write is rejected even if RD_EN=1 in the same cycle (the read proceeds). OVERFLOW pulses on the next cycle. No state change from the write.
- Empty: the read is rejected even if WR_EN=1 in the same cycle (the write proceeds). UNDERFLOW pulses. DOUT holds.
- Address collision is impossible: read and write of the same address can only coincide at count 0 or 16, and one side is blocked there.
- Pointer wrap: 15 -> 0 with no gap. Full and empty are distinguished by count, not by pointer equality.
- Reset (RSTN low, at any time, including mid-burst):
  - wptr=0, rptr=0, COUNT=0.
  - EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
  - DOUT=0, OVERFLOW=0, UNDERFLOW=0.
  - RAM contents are not cleared; stale data is unreachable.
- Leaving reset: first edge with RSTN high is the first active edge.

## Timing
- Write to EMPTY deassert: 1 cycle (a write at edge n gives EMPTY=0 after edge n).
- Read latency: RD_EN sampled at edge n gives DOUT valid after edge n.
- Write-to-read minimum: data written at edge n can be read at edge n+1 and appears on DOUT after n+1.
- Throughput: one write and one read per cycle, sustained, when 0 < count < 16.
- OVERFLOW/UNDERFLOW: high for exactly the cycle after the rejected request; repeated rejects give continuous high.
- All outputs are registered except the RAM address and WE drive, which are combinational from the pointers and wr_ok.

## Structure
- Package x_ramd16_fifo_pkg holds:
  - DEPTH=16, AW=4, CW=5;
  - reset values for the flags;
  - a function computing flags from a count and the AF/AE levels.
- Storage: generate loop of WIDTH X_RAMD16 instances with INIT=16'h0000. Each shares WADR, RADR, WE and CLK and takes one DIN bit.
- One natural sub-module: x_ramd16_fifo_ctrl (pointers, count, flags, pulses). The top holds only the RAM array and the DOUT register.
- Timescale 1 ps/1 ps.

## Test plan
- Reset, then write 16 words 0x01..0x10 -> FULL=1 and COUNT=16 after the 16th edge; ALMOST_FULL=1 from count 14.
- Read 16 words -> DOUT = 0x01..0x10 in order, each one cycle after its RD_EN; EMPTY=1 after the last; ALMOST_EMPTY=1 at count<=2.
- At count 5, assert WR_EN and RD_EN together for 40 cycles with an incrementing DIN -> COUNT stays 5; data is in order across pointer wrap; no pulses.
- At full, write 0xAA with RD_EN=1 -> OVERFLOW=1 for one cycle, COUNT=15, and 0xAA never appears on DOUT.
- At empty, read with WR_EN=1 and DIN=0x3C -> UNDERFLOW=1, DOUT unchanged, COUNT=1; the next read returns 0x3C.
- At count 9, drop RSTN asynchronously between edges -> all outputs at reset values immediately; a subsequent write/read of 0x55 returns 0x55.
